// File: rtl/ultrasonido_filtro.sv
// Ultrasonic echo post-processing: µs-to-cm restoring divider, 4-sample moving
// average and hysteretic proximity flag with one-cycle near/far events.
module ultrasonido_filtro #(
    parameter int unsigned DIV_US_CM    = 58,
    parameter int unsigned MAX_CM       = 400,
    parameter int unsigned UMBRAL_CERCA = 50,
    parameter int unsigned UMBRAL_LEJOS = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] echo_us,
    input  logic        echo_valid,
    input  logic        echo_timeout,
    output logic [8:0]  distancia_cm,
    output logic [8:0]  promedio_cm,
    output logic        dist_valid,
    output logic        cerca,
    output logic        evento_cerca,
    output logic        evento_lejos,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 9;
    localparam int unsigned SW = 11;
    localparam int unsigned RW = 7;
    localparam int unsigned NB = 4;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        AVERAGE,
        COMPARE
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   dividend_q, dividend_d;
    logic [DW-1:0]   quot_q, quot_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CW-1:0]   smp_q [NB];
    logic [CW-1:0]   smp_d [NB];
    logic [1:0]      ptr_q, ptr_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [CW-1:0]   distancia_q, distancia_d;
    logic [CW-1:0]   promedio_q, promedio_d;
    logic            dist_valid_q, dist_valid_d;
    logic            cerca_q, cerca_d;
    logic            ev_cerca_q, ev_cerca_d;
    logic            ev_lejos_q, ev_lejos_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;

    logic [RW:0]     trial;
    logic [CW-1:0]   q_sat;
    logic [CW-1:0]   avg;

    // Restoring division step: shift the next dividend bit into the partial remainder.
    assign trial = {rem_q, dividend_q[DW-1]};
    assign q_sat = (quot_q > DW'(MAX_CM)) ? CW'(MAX_CM) : quot_q[CW-1:0];
    assign avg   = sum_q[SW-1:2];

    always_comb begin
        state_d      = state_q;
        dividend_d   = dividend_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        smp_d        = smp_q;
        ptr_d        = ptr_q;
        sum_d        = sum_q;
        distancia_d  = distancia_q;
        promedio_d   = promedio_q;
        dist_valid_d = 1'b0;
        cerca_d      = cerca_q;
        ev_cerca_d   = 1'b0;
        ev_lejos_d   = 1'b0;
        overrun_d    = overrun_q;

        if (state_q != IDLE && (echo_valid || echo_timeout)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (echo_timeout) begin
                    quot_d  = DW'(MAX_CM);
                    state_d = AVERAGE;
                end else if (echo_valid) begin
                    dividend_d = echo_us;
                    quot_d     = '0;
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = DIVIDE;
                end
            end
            DIVIDE: begin
                dividend_d = {dividend_q[DW-2:0], 1'b0};
                if (trial >= (RW + 1)'(DIV_US_CM)) begin
                    rem_d  = RW'(trial - (RW + 1)'(DIV_US_CM));
                    quot_d = {quot_q[DW-2:0], 1'b1};
                end else begin
                    rem_d  = trial[RW-1:0];
                    quot_d = {quot_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = AVERAGE;
                end
            end
            AVERAGE: begin
                // Saturated quotient is kept in quot_q for the COMPARE stage.
                quot_d        = DW'(q_sat);
                sum_d         = sum_q - SW'(smp_q[ptr_q]) + SW'(q_sat);
                smp_d[ptr_q]  = q_sat;
                ptr_d         = ptr_q + 2'd1;
                state_d       = COMPARE;
            end
            COMPARE: begin
                distancia_d  = quot_q[CW-1:0];
                promedio_d   = avg;
                dist_valid_d = 1'b1;
                if (!cerca_q && (avg < CW'(UMBRAL_CERCA))) begin
                    cerca_d    = 1'b1;
                    ev_cerca_d = 1'b1;
                end else if (cerca_q && (avg >= CW'(UMBRAL_LEJOS))) begin
                    cerca_d    = 1'b0;
                    ev_lejos_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            dividend_q   <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < NB; i++) begin
                smp_q[i] <= CW'(MAX_CM);
            end
            ptr_q        <= '0;
            sum_q        <= SW'(NB * MAX_CM);
            distancia_q  <= '0;
            promedio_q   <= '0;
            dist_valid_q <= 1'b0;
            cerca_q      <= 1'b0;
            ev_cerca_q   <= 1'b0;
            ev_lejos_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dividend_q   <= dividend_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            smp_q        <= smp_d;
            ptr_q        <= ptr_d;
            sum_q        <= sum_d;
            distancia_q  <= distancia_d;
            promedio_q   <= promedio_d;
            dist_valid_q <= dist_valid_d;
            cerca_q      <= cerca_d;
            ev_cerca_q   <= ev_cerca_d;
            ev_lejos_q   <= ev_lejos_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign distancia_cm = distancia_q;
    assign promedio_cm  = promedio_q;
    assign dist_valid   = dist_valid_q;
    assign cerca        = cerca_q;
    assign evento_cerca = ev_cerca_q;
    assign evento_lejos = ev_lejos_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ultrasonido_filtro.sv
// Directed self-checking bench for ultrasonido_filtro.
module tb_ultrasonido_filtro;

    logic        clk;
    logic        reset;
    logic [15:0] echo_us;
    logic        echo_valid;
    logic        echo_timeout;
    logic [8:0]  distancia_cm;
    logic [8:0]  promedio_cm;
    logic        dist_valid;
    logic        cerca;
    logic        evento_cerca;
    logic        evento_lejos;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    int cap_dist, cap_prom, cap_cerca, cap_evc, cap_evl, lat;

    ultrasonido_filtro dut (
        .clk          (clk),
        .reset        (reset),
        .echo_us      (echo_us),
        .echo_valid   (echo_valid),
        .echo_timeout (echo_timeout),
        .distancia_cm (distancia_cm),
        .promedio_cm  (promedio_cm),
        .dist_valid   (dist_valid),
        .cerca        (cerca),
        .evento_cerca (evento_cerca),
        .evento_lejos (evento_lejos),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise the requested strobes for exactly one accepting edge once idle.
    task automatic strobe(input logic v, input logic t, input logic [15:0] us);
        for (int i = 0; i < 100 && busy; i++) step();
        if (busy) chk("idle_wait", 1, 0);
        echo_valid   = v;
        echo_timeout = t;
        echo_us      = us;
        step();
        echo_valid   = 1'b0;
        echo_timeout = 1'b0;
    endtask

    // Count edges after the accepting edge until dist_valid; capture outputs.
    task automatic wait_dv();
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            if (lat < 0) begin
                step();
                if (dist_valid) begin
                    lat       = i;
                    cap_dist  = int'(distancia_cm);
                    cap_prom  = int'(promedio_cm);
                    cap_cerca = int'(cerca);
                    cap_evc   = int'(evento_cerca);
                    cap_evl   = int'(evento_lejos);
                end
            end
        end
        if (lat < 0) begin
            chk("dv_timeout", 0, 1);
        end else begin
            step();
            chk("dv_pulse_end", int'(dist_valid), 0);
            chk("evc_pulse_end", int'(evento_cerca), 0);
            chk("evl_pulse_end", int'(evento_lejos), 0);
        end
    endtask

    task automatic run_echo(input logic [15:0] us);
        strobe(1'b1, 1'b0, us);
        wait_dv();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    int exp_prom2 [4] = '{307, 215, 122, 30};
    int exp_prom3 [4] = '{56, 57, 58, 60};

    initial begin
        reset        = 1'b1;
        echo_us      = '0;
        echo_valid   = 1'b0;
        echo_timeout = 1'b0;
        #2;
        chk("rst_dist", int'(distancia_cm), 0);
        chk("rst_prom", int'(promedio_cm), 0);
        chk("rst_dv", int'(dist_valid), 0);
        chk("rst_cerca", int'(cerca), 0);
        chk("rst_evc", int'(evento_cerca), 0);
        chk("rst_evl", int'(evento_lejos), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(overrun), 0);
        step();
        reset = 1'b0;
        step();

        // Test 1: single 50 cm sample against a buffer full of 400.
        strobe(1'b1, 1'b0, 16'd2900);
        chk("t1_busy", int'(busy), 1);
        wait_dv();
        chk("t1_lat", lat, 18);
        chk("t1_dist", cap_dist, 50);
        chk("t1_prom", cap_prom, 312);
        chk("t1_cerca", cap_cerca, 0);
        chk("t1_busy_idle", int'(busy), 0);

        // Test 2: four 30 cm samples from a fresh buffer.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_echo(16'd1740);
            chk("t2_dist", cap_dist, 30);
            chk("t2_prom", cap_prom, exp_prom2[i]);
            chk("t2_cerca", cap_cerca, (i == 3) ? 1 : 0);
            chk("t2_evc", cap_evc, (i == 3) ? 1 : 0);
            chk("t2_evl", cap_evl, 0);
        end

        // Test 3: 55 cm stays inside the hysteresis band, 60 cm releases it.
        for (int i = 0; i < 4; i++) begin
            run_echo(16'd3190);
            chk("t3a_dist", cap_dist, 55);
            chk("t3a_cerca", cap_cerca, 1);
            chk("t3a_ev", cap_evc + cap_evl, 0);
        end
        chk("t3a_prom", cap_prom, 55);
        for (int i = 0; i < 4; i++) begin
            run_echo(16'd3480);
            chk("t3b_prom", cap_prom, exp_prom3[i]);
            chk("t3b_cerca", cap_cerca, (i == 3) ? 0 : 1);
            chk("t3b_evl", cap_evl, (i == 3) ? 1 : 0);
            chk("t3b_evc", cap_evc, 0);
        end

        // Test 4: arithmetic edges.
        run_echo(16'd57);
        chk("t4_57", cap_dist, 0);
        run_echo(16'd58);
        chk("t4_58", cap_dist, 1);
        run_echo(16'd65535);
        chk("t4_sat", cap_dist, 400);
        strobe(1'b0, 1'b1, 16'd0);
        wait_dv();
        chk("t4_to_lat", lat, 2);
        chk("t4_to_dist", cap_dist, 400);

        // Test 5b: simultaneous strobes in IDLE take the timeout, no overrun.
        strobe(1'b1, 1'b1, 16'd58);
        wait_dv();
        chk("t5b_lat", lat, 2);
        chk("t5b_dist", cap_dist, 400);
        chk("t5b_ovr", int'(overrun), 0);

        // Test 5a: strobe during DIVIDE is dropped and flags overrun.
        strobe(1'b1, 1'b0, 16'd2900);
        for (int i = 0; i < 4; i++) step();
        echo_valid = 1'b1;
        echo_us    = 16'd58;
        step();
        echo_valid = 1'b0;
        chk("t5a_ovr_set", int'(overrun), 1);
        wait_dv();
        chk("t5a_dist", cap_dist, 50);
        run_echo(16'd1740);
        chk("t5a_dist2", cap_dist, 30);
        chk("t5a_ovr_sticky", int'(overrun), 1);

        // Test 6: asynchronous reset in the middle of DIVIDE.
        strobe(1'b1, 1'b0, 16'd2900);
        for (int i = 0; i < 5; i++) step();
        #3;
        reset = 1'b1;
        #1;
        chk("t6_dist", int'(distancia_cm), 0);
        chk("t6_prom", int'(promedio_cm), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ovr", int'(overrun), 0);
        chk("t6_cerca", int'(cerca), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (dist_valid) chk("t6_no_dv", 1, 0);
        end
        reset = 1'b0;
        step();
        chk("t6_idle_dv", int'(dist_valid), 0);
        run_echo(16'd2900);
        chk("t6_refill_dist", cap_dist, 50);
        chk("t6_refill_prom", cap_prom, 312);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ultrasonido_filtro.md
Name: ultrasonido_filtro

Overview:
- Downstream stage of the ultrasonic ranging driver.
- Consumes each completed echo measurement (pulse width in µs, or a no-echo timeout) and converts it to centimetres.
- Smooths the result with a 4-sample moving average and drives a hysteretic proximity flag with one-cycle near/far events.
- Feeds the pet-interaction logic, which reacts to someone approaching the device.

Parameters:
- DIV_US_CM, 58: µs of echo per cm of distance; divisor, 7 bits.
- MAX_CM, 400: saturation distance in cm; also the value used for a timeout.
- UMBRAL_CERCA, 50: proximity sets when average < this value.
- UMBRAL_LEJOS, 60: proximity clears when average >= this value. Must be > UMBRAL_CERCA.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- echo_us  in  16  echo pulse width in µs; sampled only when a strobe is accepted
- echo_valid  in  1  one-cycle strobe: new measurement on echo_us
- echo_timeout  in  1  one-cycle strobe: sensor returned no echo
- distancia_cm  out  9  latest single-sample distance, saturated to MAX_CM
- promedio_cm  out  9  mean of the last 4 samples
- dist_valid  out  1  one-cycle pulse when both distance outputs update
- cerca  out  1  hysteretic proximity flag
- evento_cerca  out  1  one-cycle pulse when cerca goes 0→1
- evento_lejos  out  1  one-cycle pulse when cerca goes 1→0
- busy  out  1  high while a sample is being processed
- overrun  out  1  sticky; a strobe arrived while busy

Behaviour:
- Single clock clk; reset is asynchronous and active-high; all state flops are reset by it.
- Reset values: distancia_cm=0, promedio_cm=0, dist_valid=0, cerca=0, evento_cerca=0, evento_lejos=0, busy=0, overrun=0, FSM=IDLE.
- Reset fills all 4 buffer entries with MAX_CM, sets running sum = 4*MAX_CM, and sets the write pointer to 0.
- Reset asserted mid-operation aborts the current sample; no dist_valid is produced for it.
- FSM states: IDLE, DIVIDE, AVERAGE, COMPARE.
- IDLE:
  - echo_timeout=1 (takes priority over echo_valid): quotient = MAX_CM, next state AVERAGE.
  - else echo_valid=1: latch echo_us, clear quotient/remainder, clear the iteration counter, next state DIVIDE.
  - busy is 0 only in IDLE.
- DIVIDE:
  - Restoring division, 1 quotient bit per cycle, MSB first, exactly 16 cycles, then AVERAGE.
  - Quotient is truncated (remainder discarded).
  - If the 16-bit quotient > MAX_CM, it saturates to MAX_CM.
- AVERAGE, one cycle, then COMPARE:
  - sum <= sum − buf[ptr] + q
  - buf[ptr] <= q
  - ptr <= ptr+1, wrapping 3→0
  - sum is 11 bits; it cannot overflow since the maximum is 4*MAX_CM = 1600.
- COMPARE, one cycle, then IDLE. Registered at this edge:
  - distancia_cm <= q
  - promedio_cm <= sum>>2 (truncated), using the updated sum
  - dist_valid <= 1
  - if cerca=0 and avg < UMBRAL_CERCA: cerca<=1, evento_cerca<=1
  - if cerca=1 and avg >= UMBRAL_LEJOS: cerca<=0, evento_lejos<=1
  - otherwise cerca holds.
- dist_valid, evento_cerca and evento_lejos are high for exactly one cycle and are 0 at all other times.
- Latency, measured from the edge k that accepts a strobe:
  - echo_valid: dist_valid is high in the cycle after edge k+18.
  - echo_timeout: dist_valid is high in the cycle after edge k+2.
  - The next strobe can be accepted at the edge after that dist_valid cycle.
- Any strobe seen while busy=1 is dropped, echo_us is not re-sampled, and overrun<=1. overrun clears only on reset.
- Both strobes in the same IDLE cycle: timeout processed, echo_valid dropped silently, no overrun.

Test Plan:
1. Reset → all outputs 0, busy=0. Single echo_valid with echo_us=2900 → dist_valid 19 edges later; distancia_cm=50, promedio_cm=312 ((50+1200)/4); cerca=0.
2. Four back-to-back samples echo_us=1740, each issued after the previous dist_valid → promedio_cm 307, 215, 122, 30. cerca rises and evento_cerca pulses together with the 4th dist_valid.
3. Hysteresis, starting from test 2:
   - four samples of 3190 (55 cm) → promedio_cm=55 after the 4th, cerca stays 1, no events;
   - then four samples of 3480 (60 cm) → promedio_cm 56, 57, 58, 60; cerca clears and evento_lejos pulses only on the 4th.
4. Arithmetic edges:
   - echo_us=57 → distancia_cm=0;
   - echo_us=58 → 1;
   - echo_us=65535 → 400 (saturated);
   - echo_timeout → distancia_cm=400, dist_valid 3 edges after the strobe.
5. echo_valid pulsed 5 cycles into DIVIDE → dropped, overrun=1 and sticky; the in-flight sample's result is unchanged. Simultaneous echo_valid+echo_timeout in IDLE → timeout result, overrun stays 0.
6. Reset asserted mid-DIVIDE → outputs return to reset values immediately (asynchronous); no dist_valid. A subsequent sample of 2900 gives promedio_cm=312 again, proving the buffer was refilled with MAX_CM.
